// File: rtl/mips_run_controller_pkg.sv
// Shared state codes, halt-mode codes and helpers for the MIPS run controller.
package mips_run_controller_pkg;

    typedef enum logic [2:0] {
        ST_RST_HOLD = 3'd0,
        ST_RUN      = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_DUMP     = 3'd3,
        ST_DONE     = 3'd4
    } run_state_t;

    localparam int HALT_END_PC    = 0;
    localparam int HALT_SELF_LOOP = 1;
    localparam int HALT_EITHER    = 2;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mips_halt_detector.sv
// Halt detection for the run controller: end-PC match and/or PC self-loop.
module mips_halt_detector
    import mips_run_controller_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter int              HALT_MODE = HALT_END_PC,
    parameter logic [PC_W-1:0] END_PC    = 'h9C
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic [PC_W-1:0] pc,
    output logic            halt
);

    localparam bit USE_END  = (HALT_MODE != HALT_SELF_LOOP);
    localparam bit USE_LOOP = (HALT_MODE != HALT_END_PC);

    logic [PC_W-1:0] prev_pc;
    logic            armed;
    logic            end_hit;
    logic            loop_hit;

    // armed only after one RUN cycle so the post-reset PC of 0 cannot match itself
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_pc <= '0;
            armed   <= 1'b0;
        end else if (run) begin
            prev_pc <= pc;
            armed   <= 1'b1;
        end
    end

    assign end_hit  = (pc == END_PC);
    assign loop_hit = armed && (pc == prev_pc);
    assign halt     = run && ((USE_END && end_hit) || (USE_LOOP && loop_hit));

endmodule

// File: rtl/mips_run_controller.sv
// Run/halt/dump sequencer for single_cycle_mips: holds the CPU in reset,
// runs it to a halt or timeout, then streams a data-memory window out.
module mips_run_controller
    import mips_run_controller_pkg::*;
#(
    parameter int              PC_W         = 32,
    parameter int              DATA_W       = 32,
    parameter int              DADDR_W      = 10,
    parameter int              RESET_CYCLES = 3,
    parameter int              HALT_MODE    = HALT_END_PC,
    parameter logic [PC_W-1:0] END_PC       = 'h9C,
    parameter int unsigned     MAX_CYCLES   = 100000,
    parameter int              DUMP_BASE    = 50,
    parameter int              DUMP_COUNT   = 21
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PC_W-1:0]    pc,
    output logic               cpu_reset,
    output logic               cpu_run_en,
    output logic [DADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic [DATA_W-1:0]  dump_data,
    output logic [DADDR_W-1:0] dump_index,
    output logic               dump_valid,
    input  logic               dump_ready,
    output logic               done,
    output logic               timed_out,
    output logic [31:0]        run_cycles
);

    localparam logic [31:0] HOLD_LAST = 32'(RESET_CYCLES - 1);
    localparam logic [31:0] RUN_LAST  = 32'(MAX_CYCLES - 1);

    localparam logic [DADDR_W-1:0] BASE_ADDR =
        DADDR_W'(DUMP_BASE);
    localparam logic [DADDR_W-1:0] LAST_ADDR =
        DADDR_W'(DUMP_BASE + DUMP_COUNT - 1);

    if (DUMP_BASE < 0 || DUMP_COUNT < 0 ||
        DUMP_BASE + DUMP_COUNT > (1 << DADDR_W)) begin : g_bad_window
        $error("mips_run_controller: dump window outside data memory");
    end
    if (RESET_CYCLES < 1) begin : g_bad_reset
        $error("mips_run_controller: RESET_CYCLES must be >= 1");
    end
    if (MAX_CYCLES < 1) begin : g_bad_max
        $error("mips_run_controller: MAX_CYCLES must be >= 1");
    end
    if (HALT_MODE < HALT_END_PC || HALT_MODE > HALT_EITHER) begin : g_bad_mode
        $error("mips_run_controller: HALT_MODE must be 0, 1 or 2");
    end

    run_state_t  state;
    logic [31:0] rst_cnt;
    logic        in_run;
    logic        halt;

    assign in_run = (state == ST_RUN);

    mips_halt_detector #(
        .PC_W      (PC_W),
        .HALT_MODE (HALT_MODE),
        .END_PC    (END_PC)
    ) u_halt (
        .clk   (clk),
        .reset (reset),
        .run   (in_run),
        .pc    (pc),
        .halt  (halt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_RST_HOLD;
            rst_cnt    <= '0;
            cpu_reset  <= 1'b1;
            cpu_run_en <= 1'b0;
            dmem_addr  <= BASE_ADDR;
            dump_valid <= 1'b0;
            done       <= 1'b0;
            timed_out  <= 1'b0;
            run_cycles <= '0;
        end else begin
            unique case (state)
                ST_RST_HOLD: begin
                    if (rst_cnt == HOLD_LAST) begin
                        state      <= ST_RUN;
                        cpu_reset  <= 1'b0;
                        cpu_run_en <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt + 32'd1;
                    end
                end
                ST_RUN: begin
                    run_cycles <= sat_inc(run_cycles);
                    // a PC halt seen on the budget's last cycle is not a timeout
                    if (halt || run_cycles == RUN_LAST) begin
                        state      <= ST_SETTLE;
                        cpu_run_en <= 1'b0;
                        timed_out  <= ~halt;
                    end
                end
                ST_SETTLE: begin
                    dmem_addr <= BASE_ADDR;
                    if (DUMP_COUNT == 0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        state      <= ST_DUMP;
                        dump_valid <= 1'b1;
                    end
                end
                ST_DUMP: begin
                    if (dump_ready) begin
                        if (dmem_addr == LAST_ADDR) begin
                            state      <= ST_DONE;
                            dump_valid <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            dmem_addr <= dmem_addr + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= ST_RST_HOLD;
                end
            endcase
        end
    end

    // address is frozen while a beat is pending, so the read data holds too
    assign dump_data  = dmem_rdata;
    assign dump_index = dmem_addr;

endmodule

// File: tb/tb_mips_run_controller.sv
// Bench for mips_run_controller: three parameter sets, scripted and random
// PC traces, reference halt prediction and a dump scoreboard.
module tb_mips_run_controller;

    localparam int LEN = 600;
    localparam int RST = 3;
    localparam int MODE [3] = '{0, 1, 2};
    localparam int ENDP [3] = '{'h9C, 'h9C, 'h24};
    localparam int MAXC [3] = '{100000, 100000, 10};
    localparam int BASE [3] = '{50, 7, 1021};
    localparam int CNT  [3] = '{21, 0, 3};

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic [31:0] pc         = '0;
    logic        dump_ready = 1'b0;
    logic [31:0] salt       = '0;

    logic [2:0]        cpu_reset_w;
    logic [2:0]        run_en_w;
    logic [2:0]        valid_w;
    logic [2:0]        done_w;
    logic [2:0]        to_w;
    logic [2:0][31:0]  rc_w;
    logic [2:0][31:0]  data_w;
    logic [2:0][31:0]  rdata_w;
    logic [2:0][9:0]   addr_w;
    logic [2:0][9:0]   idx_w;

    logic [31:0] seq [0:LEN];
    int          total = 0;
    int          bad   = 0;
    int          kh;
    logic        exp_to;

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [9:0] a,
                                         input logic [31:0] s);
        return (32'(a) * 32'd3) ^ s;
    endfunction

    assign rdata_w[0] = memw(addr_w[0], salt);
    assign rdata_w[1] = memw(addr_w[1], salt);
    assign rdata_w[2] = memw(addr_w[2], salt);

    mips_run_controller #(
        .HALT_MODE(MODE[0]), .END_PC(ENDP[0]), .MAX_CYCLES(MAXC[0]),
        .DUMP_BASE(BASE[0]), .DUMP_COUNT(CNT[0])
    ) u0 (
        .clk(clk), .reset(reset), .pc(pc),
        .cpu_reset(cpu_reset_w[0]), .cpu_run_en(run_en_w[0]),
        .dmem_addr(addr_w[0]), .dmem_rdata(rdata_w[0]),
        .dump_data(data_w[0]), .dump_index(idx_w[0]),
        .dump_valid(valid_w[0]), .dump_ready(dump_ready),
        .done(done_w[0]), .timed_out(to_w[0]), .run_cycles(rc_w[0])
    );

    mips_run_controller #(
        .HALT_MODE(MODE[1]), .END_PC(ENDP[1]), .MAX_CYCLES(MAXC[1]),
        .DUMP_BASE(BASE[1]), .DUMP_COUNT(CNT[1])
    ) u1 (
        .clk(clk), .reset(reset), .pc(pc),
        .cpu_reset(cpu_reset_w[1]), .cpu_run_en(run_en_w[1]),
        .dmem_addr(addr_w[1]), .dmem_rdata(rdata_w[1]),
        .dump_data(data_w[1]), .dump_index(idx_w[1]),
        .dump_valid(valid_w[1]), .dump_ready(dump_ready),
        .done(done_w[1]), .timed_out(to_w[1]), .run_cycles(rc_w[1])
    );

    mips_run_controller #(
        .HALT_MODE(MODE[2]), .END_PC(ENDP[2]), .MAX_CYCLES(MAXC[2]),
        .DUMP_BASE(BASE[2]), .DUMP_COUNT(CNT[2])
    ) u2 (
        .clk(clk), .reset(reset), .pc(pc),
        .cpu_reset(cpu_reset_w[2]), .cpu_run_en(run_en_w[2]),
        .dmem_addr(addr_w[2]), .dmem_rdata(rdata_w[2]),
        .dump_data(data_w[2]), .dump_index(idx_w[2]),
        .dump_valid(valid_w[2]), .dump_ready(dump_ready),
        .done(done_w[2]), .timed_out(to_w[2]), .run_cycles(rc_w[2])
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build_linear(input int stick);
        for (int k = 1; k <= LEN; k++) begin
            seq[k] = 32'(4 * (k - 1));
            if (stick >= 0 && seq[k] > 32'(stick)) seq[k] = 32'(stick);
        end
        seq[0] = '0;
    endtask

    task automatic build_away();
        seq[0] = '0;
        seq[1] = '0;
        for (int k = 2; k <= LEN; k++) seq[k] = 32'h100 + 32'(4 * k);
    endtask

    task automatic build_random(input int s);
        int r;
        seq[0] = '0;
        seq[1] = '0;
        for (int k = 2; k <= LEN; k++) begin
            r = $urandom_range(0, 15);
            if (r == 0)     seq[k] = seq[k-1];
            else if (r < 3) seq[k] = 32'($urandom_range(0, 63) * 4);
            else            seq[k] = (seq[k-1] + 32'd4) & 32'hFC;
        end
        seq[LEN] = (MODE[s] == 1) ? seq[LEN-1] : 32'(ENDP[s]);
    endtask

    // first RUN cycle k at which a halt rule or the cycle budget fires
    task automatic predict(input int s);
        logic e, l;
        kh = 0;
        exp_to = 1'b0;
        for (int k = 1; k <= LEN; k++) begin
            if (kh == 0) begin
                e = (MODE[s] != 1) && (seq[k] == 32'(ENDP[s]));
                l = (MODE[s] != 0) && (k >= 2) && (seq[k] == seq[k-1]);
                if (e || l) kh = k;
                else if (k == MAXC[s]) begin
                    kh = k;
                    exp_to = 1'b1;
                end
            end
        end
    endtask

    task automatic start(input int s);
        reset = 1'b1;
        pc = '0;
        dump_ready = 1'b0;
        tick();
        check("rst_cpu_reset", cpu_reset_w[s], 1);
        check("rst_run_en", run_en_w[s], 0);
        check("rst_valid", valid_w[s], 0);
        check("rst_done", done_w[s], 0);
        check("rst_timed_out", to_w[s], 0);
        check("rst_run_cycles", rc_w[s], 0);
        check("rst_dmem_addr", addr_w[s], BASE[s]);
        reset = 1'b0;
        for (int i = 1; i < RST; i++) begin
            tick();
            check("hold_cpu_reset", cpu_reset_w[s], 1);
            check("hold_run_en", run_en_w[s], 0);
        end
        tick();
    endtask

    task automatic run(input int s);
        predict(s);
        for (int k = 1; k <= kh; k++) begin
            pc = seq[k];
            check("run_en", run_en_w[s], 1);
            check("run_cpu_reset", cpu_reset_w[s], 0);
            check("run_cycles_live", rc_w[s], k - 1);
            tick();
        end
        check("halt_run_en", run_en_w[s], 0);
        check("run_cycles", rc_w[s], kh);
        check("timed_out", to_w[s], exp_to);
        check("settle_valid", valid_w[s], 0);
        check("settle_done", done_w[s], 0);
        check("settle_addr", addr_w[s], BASE[s]);
    endtask

    task automatic dump(input int s, input int rmode, input int abort_at);
        int   idx   = BASE[s];
        int   beats = 0;
        int   cyc   = 0;
        logic r;
        tick();
        while (beats < CNT[s] && cyc < 400) begin
            check("dump_valid", valid_w[s], 1);
            check("dump_done", done_w[s], 0);
            check("dump_index", idx_w[s], idx);
            check("dump_data", data_w[s], memw(10'(idx), salt));
            if (beats == abort_at) return;
            case (rmode)
                0:       r = 1'b1;
                1:       r = (cyc % 2 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            dump_ready = r;
            tick();
            cyc++;
            if (r) begin
                beats++;
                idx++;
            end
        end
        check("dump_beats", beats, CNT[s]);
        for (int i = 0; i < 3; i++) begin
            check("done", done_w[s], 1);
            check("done_valid", valid_w[s], 0);
            check("done_run_en", run_en_w[s], 0);
            check("done_cpu_reset", cpu_reset_w[s], 0);
            check("done_run_cycles", rc_w[s], kh);
            check("done_timed_out", to_w[s], exp_to);
            dump_ready = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    initial begin
        salt = '0;
        build_linear(-1);
        start(0); run(0); dump(0, 0, -1);
        start(0); run(0); dump(0, 1, 5);
        start(0); run(0); dump(0, 1, -1);
        repeat (3) begin
            salt = $urandom;
            build_random(0);
            start(0); run(0); dump(0, 2, -1);
        end
        build_linear('h20);
        start(1); run(1); dump(1, 0, -1);
        repeat (3) begin
            build_random(1);
            start(1); run(1); dump(1, 2, -1);
        end
        salt = $urandom;
        build_away();
        start(2); run(2); dump(2, 2, -1);
        build_linear(-1);
        start(2); run(2); dump(2, 1, -1);
        repeat (4) begin
            salt = $urandom;
            build_random(2);
            start(2); run(2); dump(2, 2, -1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
